// File: rtl/recent_list_reporter_if.sv
// Record stream from the reporter toward the host/statistics side.
// The master drives the record and its valid; the slave returns ready.
interface recent_list_reporter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] m_data_out;
    logic              m_hit_out;
    logic [1:0]        m_idx_out;
    logic              m_valid_out;
    logic              m_ready_in;

    modport master (
        output m_data_out,
        output m_hit_out,
        output m_idx_out,
        output m_valid_out,
        input  m_ready_in
    );

    modport slave (
        input  m_data_out,
        input  m_hit_out,
        input  m_idx_out,
        input  m_valid_out,
        output m_ready_in
    );
endinterface

// File: rtl/recent_list_reporter.sv
// Purpose: turns each change of the recent list's front entry into a {value, hit, idx} record, buffered in a FIFO.
// Latency: record visible one cycle after the event edge. Backpressure: FIFO absorbs stalls; pushes into a full FIFO without a pop are dropped.
// Optional: REPORTER_DROP_CNT_EN adds the saturating drop counter; otherwise drop_cnt_out reads 0.

module rlr_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_i,
    output logic [W-1:0] rd_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_ok, rd_ok;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign rd_ok    = rd_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_ok    = wr_i && (!full_o || rd_ok);
    assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
endmodule

module recent_list_reporter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   clr_in,
    input  logic [DATA_W-1:0]      in_0,
    input  logic [DATA_W-1:0]      in_1,
    input  logic [DATA_W-1:0]      in_2,
    input  logic [DATA_W-1:0]      in_3,
    input  logic                   in_valid_0,
    input  logic                   in_valid_1,
    input  logic                   in_valid_2,
    input  logic                   in_valid_3,
    recent_list_reporter_if.master m_if,
    output logic [CNT_W-1:0]       drop_cnt_out,
    output logic                   overflow_out
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hit;
        logic [1:0]        idx;
    } rec_t;

    logic [DATA_W-1:0] cur_list [4];
    logic [3:0]        cur_vld;
    logic [DATA_W-1:0] prev_q [4];
    logic [DATA_W-1:0] prev_d [4];
    logic [3:0]        prev_vld_q, prev_vld_d;
    logic              overflow_q, overflow_d;

    logic       evt, hit, push, pop, drop, fifo_empty, fifo_full;
    logic [1:0] idx;
    rec_t       rec_in, rec_head;

    assign cur_list[0] = in_0;
    assign cur_list[1] = in_1;
    assign cur_list[2] = in_2;
    assign cur_list[3] = in_3;
    assign cur_vld     = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

    assign evt = in_valid_0 && (!prev_vld_q[0] || (in_0 != prev_q[0]));

    // Lowest matching previous index wins.
    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        if (prev_vld_q[1] && (prev_q[1] == in_0)) begin
            hit = 1'b1;
            idx = 2'd1;
        end else if (prev_vld_q[2] && (prev_q[2] == in_0)) begin
            hit = 1'b1;
            idx = 2'd2;
        end else if (prev_vld_q[3] && (prev_q[3] == in_0)) begin
            hit = 1'b1;
            idx = 2'd3;
        end
    end

    assign rec_in = '{data: in_0, hit: hit, idx: idx};
    assign push   = evt && !clr_in;
    assign pop    = m_if.m_valid_out && m_if.m_ready_in && !clr_in;
    assign drop   = push && fifo_full && !pop;

    rlr_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_in),
        .rst_n_i  (reset_n_in),
        .clr_i    (clr_in),
        .wr_i     (push),
        .wr_dat_i (rec_in),
        .rd_i     (pop),
        .rd_dat_o (rec_head),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign m_if.m_valid_out = !fifo_empty;
    assign m_if.m_data_out  = rec_head.data;
    assign m_if.m_hit_out   = rec_head.hit;
    assign m_if.m_idx_out   = rec_head.idx;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prev_d[k] = clr_in ? '0 : cur_list[k];
        end
        prev_vld_d = clr_in ? 4'd0 : cur_vld;
        overflow_d = clr_in ? 1'b0 : (overflow_q || drop);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int k = 0; k < 4; k++) prev_q[k] <= '0;
            prev_vld_q <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) prev_q[k] <= prev_d[k];
            prev_vld_q <= prev_vld_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_out = overflow_q;

`ifdef REPORTER_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_in) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) drop_cnt_q <= '0;
        else             drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_out = drop_cnt_q;
`else
    assign drop_cnt_out = '0;
`endif
endmodule

// File: tb/tb_recent_list_reporter.sv
// Directed and random bench for recent_list_reporter against a queue-based reference model.
module tb_recent_list_reporter;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk_in = 1'b0;
    logic              reset_n_in;
    logic              clr_in;
    logic [DATA_W-1:0] in_0, in_1, in_2, in_3;
    logic              in_valid_0, in_valid_1, in_valid_2, in_valid_3;
    logic [CNT_W-1:0]  drop_cnt_out;
    logic              overflow_out;

    recent_list_reporter_if #(.DATA_W(DATA_W)) rif ();

    recent_list_reporter #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .clr_in       (clr_in),
        .in_0         (in_0),
        .in_1         (in_1),
        .in_2         (in_2),
        .in_3         (in_3),
        .in_valid_0   (in_valid_0),
        .in_valid_1   (in_valid_1),
        .in_valid_2   (in_valid_2),
        .in_valid_3   (in_valid_3),
        .m_if         (rif),
        .drop_cnt_out (drop_cnt_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int d;
        int h;
        int i;
    } rec_m_t;

    rec_m_t mq[$];
    int     pm[4];
    bit     pvm[4];
    int     m_cnt;
    bit     m_ovf;
    int     n_vec = 0;
    int     n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef REPORTER_DROP_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic void model_clear();
        mq.delete();
        for (int k = 0; k < 4; k++) begin
            pm[k]  = 0;
            pvm[k] = 1'b0;
        end
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        rec_m_t hd;
        hd = '{d: 0, h: 0, i: 0};
        if (mq.size() != 0) hd = mq[0];
        check({tag, ".vld"},  {31'd0, rif.m_valid_out}, (mq.size() != 0) ? 32'd1 : 32'd0);
        check({tag, ".data"}, {24'd0, rif.m_data_out},  hd.d);
        check({tag, ".hit"},  {31'd0, rif.m_hit_out},   hd.h);
        check({tag, ".idx"},  {30'd0, rif.m_idx_out},   hd.i);
        check({tag, ".cnt"},  {24'd0, drop_cnt_out},    exp_cnt());
        check({tag, ".ovf"},  {31'd0, overflow_out},    {31'd0, m_ovf});
    endtask

    task automatic set_list(input int a0, input int a1, input int a2, input int a3, input logic [3:0] v);
        in_0 = a0[7:0];
        in_1 = a1[7:0];
        in_2 = a2[7:0];
        in_3 = a3[7:0];
        {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = v;
    endtask

    // Predicts the effect of the coming edge from the current inputs, then checks after it.
    task automatic tick(input string tag);
        int li[4];
        bit lv[4];
        bit pop, ev;
        int h, ix;
        li[0] = int'(in_0); li[1] = int'(in_1); li[2] = int'(in_2); li[3] = int'(in_3);
        lv[0] = in_valid_0; lv[1] = in_valid_1; lv[2] = in_valid_2; lv[3] = in_valid_3;
        if (clr_in) begin
            model_clear();
        end else begin
            pop = (mq.size() != 0) && rif.m_ready_in;
            ev  = lv[0] && (!pvm[0] || li[0] != pm[0]);
            h = 0;
            ix = 0;
            for (int k = 1; k < 4; k++) begin
                if (h == 0 && pvm[k] && pm[k] == li[0]) begin
                    h  = 1;
                    ix = k;
                end
            end
            if (pop) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back('{d: li[0], h: h, i: ix});
                end else begin
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    m_ovf = 1'b1;
                end
            end
            pm  = li;
            pvm = lv;
        end
        @(posedge clk_in);
        #1;
        compare_all(tag);
    endtask

    task automatic reset_now(input string tag);
        reset_n_in = 1'b0;
        #1;
        model_clear();
        compare_all(tag);
        @(negedge clk_in);
        reset_n_in = 1'b1;
    endtask

    initial begin
        reset_n_in     = 1'b0;
        clr_in         = 1'b0;
        rif.m_ready_in = 1'b0;
        set_list(0, 0, 0, 0, 4'b0000);
        model_clear();
        #12;
        compare_all("reset");
        @(negedge clk_in);
        reset_n_in = 1'b1;

        // New value, then holding it produces nothing further.
        rif.m_ready_in = 1'b1;
        set_list(5, 0, 0, 0, 4'b0001);
        tick("new5");
        check("new5.const", {24'd0, rif.m_data_out}, 32'd5);
        tick("hold5a");
        tick("hold5b");
        check("hold5.empty", {31'd0, rif.m_valid_out}, 32'd0);

        // Re-use from index 2, then a fresh value.
        set_list(1, 2, 3, 4, 4'hF);
        tick("l1234");
        set_list(3, 1, 2, 4, 4'hF);
        tick("hit3");
        check("hit3.idx", {30'd0, rif.m_idx_out}, 32'd2);
        check("hit3.hit", {31'd0, rif.m_hit_out}, 32'd1);
        set_list(9, 3, 1, 2, 4'hF);
        tick("miss9");
        check("miss9.hit", {31'd0, rif.m_hit_out}, 32'd0);
        tick("drain9");

        // Front drops to invalid and returns with the same value: still an event.
        set_list(9, 3, 1, 2, 4'b1110);
        tick("inv");
        set_list(9, 3, 1, 2, 4'hF);
        tick("revalid");
        check("revalid.vld", {31'd0, rif.m_valid_out}, 32'd1);
        tick("drainrv");

        // Overflow under a stalled consumer.
        rif.m_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_list(20 + i, 0, 0, 0, 4'b0001);
            tick("ovf");
        end
`ifdef REPORTER_DROP_CNT_EN
        check("ovf.cnt2", {24'd0, drop_cnt_out}, 32'd2);
`else
        check("ovf.cnt0", {24'd0, drop_cnt_out}, 32'd0);
`endif
        check("ovf.flag", {31'd0, overflow_out}, 32'd1);

        // Full FIFO: event and pop together, nothing dropped.
        set_list(26, 0, 0, 0, 4'b0001);
        rif.m_ready_in = 1'b1;
        tick("fullpush");
        for (int i = 0; i < 5; i++) tick("drain");
        check("drain.empty", {31'd0, rif.m_valid_out}, 32'd0);

        // Flush with records queued and a same-cycle event.
        rif.m_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_list(30 + i, 0, 0, 0, 4'b0001);
            tick("preclr");
        end
        set_list(33, 0, 0, 0, 4'b0001);
        clr_in = 1'b1;
        tick("clr");
        clr_in = 1'b0;
        check("clr.vld", {31'd0, rif.m_valid_out}, 32'd0);
        check("clr.ovf", {31'd0, overflow_out}, 32'd0);
        tick("postclr");

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            set_list(40 + i, 0, 0, 0, 4'b0001);
            tick("prerst");
        end
        rif.m_ready_in = 1'b1;
        tick("middrain");
        reset_now("midrst");

        // Random traffic over a small value range so hits are common.
        for (int n = 0; n < 400; n++) begin
            set_list($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7),
                     {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0)});
            rif.m_ready_in = ($urandom_range(0, 2) == 0);
            clr_in = ($urandom_range(0, 59) == 0);
            tick("rnd");
            clr_in = 1'b0;
            if ($urandom_range(0, 149) == 0) reset_now("rndrst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
